// File: rtl/tap_read_seq_if.sv
// Frame handshake bundle between the per-sample read sequencer and its host/transmit side.
// The sequencer (slave) takes frame requests and drives strobes, status and the sample address.
interface tap_read_seq_if #(
  parameter int N_CH   = 3,
  parameter int ADDR_W = 16
);
  logic              start;
  logic [N_CH-1:0]   ch_en;
  logic              transmit;
  logic [N_CH-1:0]   rd_strobe;
  logic              tfr_ready;
  logic              inc_adr;
  logic [ADDR_W-1:0] adr;
  logic              busy;
  logic              overrun;

  modport master (
    output start, ch_en, transmit,
    input  rd_strobe, tfr_ready, inc_adr, adr, busy, overrun
  );

  modport slave (
    input  start, ch_en, transmit,
    output rd_strobe, tfr_ready, inc_adr, adr, busy, overrun
  );
endinterface

// File: rtl/tap_read_seq.sv
// Per-frame sample-memory read sequencer: strobes enabled channels, hands the frame to the
// transmit side, then advances the shared sample address with wrap at DEPTH.
//
// state | meaning
// IDLE  | waiting for start; latches channel mask on accept
// READ  | rd_strobe held on channel ch for RD_LAT cycles
// XFER  | tfr_ready high until transmit is sampled
// INC   | inc_adr pulse, new address visible
module tap_read_seq #(
  parameter int N_CH   = 3,
  parameter int RD_LAT = 1,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 65536
) (
  input  logic          clk,
  input  logic          reset,
  tap_read_seq_if.slave bus
);
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0] ADR_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, READ, XFER, INC} state_t;

  state_t            state;
  logic [N_CH-1:0]   en_q;
  logic [CH_W-1:0]   ch;
  logic [CNT_W-1:0]  cnt;
  logic [CH_W-1:0]   first_ch;
  logic [CH_W-1:0]   nxt_ch;
  logic              first_found;
  logic              nxt_found;

  // Scanning downwards leaves the lowest qualifying bit as the winner.
  always_comb begin
    first_found = 1'b0;
    first_ch    = '0;
    nxt_found   = 1'b0;
    nxt_ch      = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (bus.ch_en[i]) begin
        first_found = 1'b1;
        first_ch    = CH_W'(i);
      end
      if (en_q[i] && (CH_W'(i) > ch)) begin
        nxt_found = 1'b1;
        nxt_ch    = CH_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      en_q          <= '0;
      ch            <= '0;
      cnt           <= '0;
      bus.adr       <= '0;
      bus.rd_strobe <= '0;
      bus.tfr_ready <= 1'b0;
      bus.inc_adr   <= 1'b0;
      bus.busy      <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      bus.overrun <= 1'b0;
      bus.inc_adr <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            en_q     <= bus.ch_en;
            cnt      <= '0;
            bus.busy <= 1'b1;
            if (first_found) begin
              state         <= READ;
              ch            <= first_ch;
              bus.rd_strobe <= N_CH'(1) << first_ch;
            end else begin
              state         <= XFER;
              bus.tfr_ready <= 1'b1;
            end
          end
        end
        READ: begin
          bus.overrun <= bus.start;
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (nxt_found) begin
              ch            <= nxt_ch;
              bus.rd_strobe <= N_CH'(1) << nxt_ch;
            end else begin
              state         <= XFER;
              bus.rd_strobe <= '0;
              bus.tfr_ready <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        XFER: begin
          bus.overrun <= bus.start;
          if (bus.transmit) begin
            state         <= INC;
            bus.tfr_ready <= 1'b0;
            bus.inc_adr   <= 1'b1;
            bus.adr       <= (bus.adr == ADR_LAST) ? '0 : bus.adr + ADDR_W'(1);
          end
        end
        INC: begin
          bus.overrun <= bus.start;
          state       <= IDLE;
          bus.busy    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tap_read_seq.sv
// Bench for tap_read_seq: two instances (RD_LAT=1/DEPTH=65536 and RD_LAT=2/DEPTH=4) share one
// stimulus stream; each cycle is compared with a frame-timeline model derived from the rules.
module tb_tap_read_seq;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [2:0] ch_en = 3'b000;
  logic       transmit = 1'b0;

  int checks = 0;
  int failures = 0;
  int adr_a = 0;
  int adr_b = 0;

  always #5 clk = ~clk;

  tap_read_seq_if #(.N_CH(3), .ADDR_W(16)) ifa ();
  tap_read_seq_if #(.N_CH(3), .ADDR_W(2))  ifb ();

  assign ifa.start    = start;
  assign ifa.ch_en    = ch_en;
  assign ifa.transmit = transmit;
  assign ifb.start    = start;
  assign ifb.ch_en    = ch_en;
  assign ifb.transmit = transmit;

  tap_read_seq #(.N_CH(3), .RD_LAT(1), .ADDR_W(16), .DEPTH(65536)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.slave));
  tap_read_seq #(.N_CH(3), .RD_LAT(2), .ADDR_W(2), .DEPTH(4)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb.slave));

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int popc(input logic [2:0] m);
    return int'(m[0]) + int'(m[1]) + int'(m[2]);
  endfunction

  // Index of the i-th set bit of m, counting from the lowest.
  function automatic int nth_set(input logic [2:0] m, input int i);
    int seen = 0;
    for (int b = 0; b < 3; b++) begin
      if (m[b]) begin
        if (seen == i) return b;
        seen++;
      end
    end
    return 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycle k counts from 1 = first cycle after the accepting edge.
  task automatic check_cycle(input string nm, input int lat, input logic [2:0] m, input int d,
                             input int k, input int prev, input int nxt, input bit ovr_exp,
                             input logic [2:0] s, input logic t, input logic i,
                             input logic [15:0] a, input logic b, input logic o);
    int n, xe, ic;
    logic [2:0] es;
    n  = popc(m) * lat;
    xe = imax(n + 1, d);
    ic = xe + 1;
    es = (k <= n) ? 3'(1 << nth_set(m, (k - 1) / lat)) : 3'b000;
    check({nm, ".rd_strobe"}, 32'(s), 32'(es));
    check({nm, ".tfr_ready"}, 32'(t), 32'((k > n) && (k <= xe)));
    check({nm, ".inc_adr"},   32'(i), 32'(k == ic));
    check({nm, ".adr"},       32'(a), 32'((k >= ic) ? nxt : prev));
    check({nm, ".busy"},      32'(b), 32'(k <= ic));
    check({nm, ".overrun"},   32'(o), 32'(ovr_exp));
  endtask

  // d: first cycle (from 1) in which transmit is high; it then stays high past the frame.
  task automatic frame(input logic [2:0] m, input int d);
    int inc_a, inc_b, kmax, nxt_a, nxt_b;
    bit ovr, ovr_n;
    ovr   = 1'b0;
    nxt_a = (adr_a + 1) % 65536;
    nxt_b = (adr_b + 1) % 4;
    inc_a = imax(popc(m) + 1, d) + 1;
    inc_b = imax(popc(m) * 2 + 1, d) + 1;
    kmax  = imax(inc_a, inc_b) + 1;
    start    = 1'b1;
    ch_en    = m;
    transmit = (d == 1);
    for (int k = 1; k <= kmax; k++) begin
      @(negedge clk);
      check_cycle("a", 1, m, d, k, adr_a, nxt_a, ovr, ifa.rd_strobe, ifa.tfr_ready,
                  ifa.inc_adr, ifa.adr, ifa.busy, ifa.overrun);
      check_cycle("b", 2, m, d, k, adr_b, nxt_b, ovr, ifb.rd_strobe, ifb.tfr_ready,
                  ifb.inc_adr, 16'(ifb.adr), ifb.busy, ifb.overrun);
      ovr_n    = (k <= imin(inc_a, inc_b)) && ($urandom_range(0, 5) == 0);
      start    = ovr_n;
      ovr      = ovr_n;
      ch_en    = 3'($urandom);
      transmit = (k >= d);
    end
    adr_a = nxt_a;
    adr_b = nxt_b;
  endtask

  initial begin
    #22 reset = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("idle.a_out", {ifa.rd_strobe, ifa.tfr_ready, ifa.inc_adr, ifa.busy, ifa.overrun}, 0);
      check("idle.a_adr", 32'(ifa.adr), 0);
      check("idle.b_out", {ifb.rd_strobe, ifb.tfr_ready, ifb.inc_adr, ifb.busy, ifb.overrun}, 0);
      check("idle.b_adr", 32'(ifb.adr), 0);
    end

    frame(3'b111, 6);
    frame(3'b101, 3);
    frame(3'b000, 1);
    frame(3'b000, 1);
    frame(3'b010, 2);
    for (int f = 0; f < 40; f++)
      frame(3'($urandom), int'($urandom_range(1, 12)));

    // Park both instances in XFER, then drop reset between clock edges.
    start    = 1'b1;
    ch_en    = 3'b011;
    transmit = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("park.a_tfr", 32'(ifa.tfr_ready), 1);
    check("park.b_tfr", 32'(ifb.tfr_ready), 1);
    #2 reset = 1'b0;
    #1;
    check("rst.a_out", {ifa.rd_strobe, ifa.tfr_ready, ifa.inc_adr, ifa.busy, ifa.overrun}, 0);
    check("rst.a_adr", 32'(ifa.adr), 0);
    check("rst.b_out", {ifb.rd_strobe, ifb.tfr_ready, ifb.inc_adr, ifb.busy, ifb.overrun}, 0);
    check("rst.b_adr", 32'(ifb.adr), 0);
    @(negedge clk);
    reset = 1'b1;
    adr_a = 0;
    adr_b = 0;
    @(negedge clk);
    frame(3'b111, 3);
    frame(3'b100, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
